// File: rtl/uart_rx_core.sv
// UART receiver: 2-flop line synchroniser, mid-bit sampling FSM with optional parity
// and 1/2 stop bits, feeding a first-word-fall-through FIFO with a valid/ready read port.
module uart_rx_core #(
   parameter int BaudRate     = 115200,
   parameter int ClockFreqHz  = 50000000,
   parameter int DataBitsSize = 8,
   parameter int ParityBit    = 0,
   parameter int StopBitsSize = 1,
   parameter int FifoDepth    = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         rx_sig,
   output logic [DataBitsSize-1:0]      rx_data,
   output logic                         rx_valid,
   input  logic                         rx_ready,
   output logic [$clog2(FifoDepth):0]   fifo_count,
   output logic                         frame_err,
   output logic                         parity_err,
   output logic                         overrun
);

   localparam int ClksPerBit = ClockFreqHz / BaudRate;
   localparam int CW = $clog2(ClksPerBit);
   localparam int BW = $clog2(DataBitsSize);
   localparam int AW = $clog2(FifoDepth);
   localparam logic [CW-1:0] BitLast  = CW'(ClksPerBit - 1);
   localparam logic [CW-1:0] HalfLast = CW'(ClksPerBit / 2 - 1);
   localparam logic [BW-1:0] DataLast = BW'(DataBitsSize - 1);
   localparam logic          StopLast = (StopBitsSize == 2);

   typedef enum logic [2:0] {WAIT_IDLE, IDLE, START, DATA, PARITY, STOP} state_t;

   state_t                  state, state_n;
   logic                    sync_p0, rxs, prev;
   logic [CW-1:0]           cnt, cnt_n;
   logic [BW-1:0]           bit_idx, bit_n;
   logic                    stop_idx, stop_n;
   logic                    par_bad, par_bad_n;
   logic                    stop_bad, stop_bad_n;
   logic [DataBitsSize-1:0] shreg, shreg_n;
   logic                    push, frame_err_n, parity_err_n;

   logic [DataBitsSize-1:0] mem [FifoDepth];
   logic [AW-1:0]           wr_ptr, rd_ptr;
   logic                    pop, full, wr_en;

   function automatic logic parity_mismatch(input logic [DataBitsSize-1:0] d, input logic p);
      logic x;
      x = (^d) ^ p;
      return (ParityBit == 1) ? !x : x;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_p0 <= 1'b1;
         rxs     <= 1'b1;
         prev    <= 1'b1;
      end else begin
         sync_p0 <= rx_sig;
         rxs     <= sync_p0;
         prev    <= rxs;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= WAIT_IDLE;
         cnt        <= '0;
         bit_idx    <= '0;
         stop_idx   <= 1'b0;
         par_bad    <= 1'b0;
         stop_bad   <= 1'b0;
         frame_err  <= 1'b0;
         parity_err <= 1'b0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         bit_idx    <= bit_n;
         stop_idx   <= stop_n;
         par_bad    <= par_bad_n;
         stop_bad   <= stop_bad_n;
         frame_err  <= frame_err_n;
         parity_err <= parity_err_n;
      end
   end

   always_ff @(posedge clk) begin
      shreg <= shreg_n;
   end

   always_comb begin
      state_n      = state;
      cnt_n        = (cnt == BitLast) ? '0 : cnt + CW'(1);
      bit_n        = bit_idx;
      stop_n       = stop_idx;
      par_bad_n    = par_bad;
      stop_bad_n   = stop_bad;
      shreg_n      = shreg;
      push         = 1'b0;
      frame_err_n  = 1'b0;
      parity_err_n = 1'b0;
      case (state)
         WAIT_IDLE: begin
            cnt_n = '0;
            if (rxs) state_n = IDLE;
         end
         IDLE: begin
            cnt_n = '0;
            if (prev && !rxs) state_n = START;
         end
         START: begin
            if (cnt == HalfLast) begin
               cnt_n = '0;
               if (rxs) begin
                  state_n = IDLE;
               end else begin
                  state_n    = DATA;
                  bit_n      = '0;
                  stop_n     = 1'b0;
                  par_bad_n  = 1'b0;
                  stop_bad_n = 1'b0;
               end
            end
         end
         DATA: begin
            if (cnt == BitLast) begin
               shreg_n = {rxs, shreg[DataBitsSize-1:1]};
               if (bit_idx == DataLast) state_n = (ParityBit != 0) ? PARITY : STOP;
               else bit_n = bit_idx + BW'(1);
            end
         end
         PARITY: begin
            if (cnt == BitLast) begin
               par_bad_n = parity_mismatch(shreg, rxs);
               state_n   = STOP;
            end
         end
         STOP: begin
            if (cnt == BitLast) begin
               if (stop_idx == StopLast) begin
                  // Framing error wins over parity and forces a wait for an idle line.
                  if (stop_bad || !rxs) begin
                     frame_err_n = 1'b1;
                     state_n     = WAIT_IDLE;
                  end else if (par_bad) begin
                     parity_err_n = 1'b1;
                     state_n      = IDLE;
                  end else begin
                     push    = 1'b1;
                     state_n = IDLE;
                  end
               end else begin
                  stop_bad_n = stop_bad | !rxs;
                  stop_n     = 1'b1;
               end
            end
         end
         default: state_n = WAIT_IDLE;
      endcase
   end

   assign rx_valid = (fifo_count != '0);
   assign rx_data  = rx_valid ? mem[rd_ptr] : '0;
   assign pop      = rx_valid && rx_ready;
   assign full     = (fifo_count == (AW+1)'(FifoDepth));
   assign wr_en    = push && (!full || pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         overrun    <= 1'b0;
      end else begin
         overrun <= push && full && !pop;
         if (wr_en) wr_ptr <= wr_ptr + AW'(1);
         if (pop)   rd_ptr <= rd_ptr + AW'(1);
         case ({wr_en, pop})
            2'b10:   fifo_count <= fifo_count + (AW+1)'(1);
            2'b01:   fifo_count <= fifo_count - (AW+1)'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= shreg;
   end

endmodule
